mem_stage: RTL
==============

# mem_stage

Memory-access pipeline stage placed directly after the ALU stage. It consumes the registered ALU result as a load/store byte address or as a pass-through writeback value. It runs a single-outstanding request/grant/response transaction on the data-memory port and holds the upstream pipeline with `stall_o` while a transaction is in flight. Its registered outputs feed the writeback stage.

## Interface
- `XLEN`, 32: datapath width. Only 32 is supported.
- `clock_i` in 1: clock.
- `nreset_i` in 1: reset, asynchronous, active-low.
- `alu_result_i` in XLEN: ALU stage result; the address for memory ops.
- `alu_bubble_i` in 1: ALU stage bubble flag; 1 means no instruction.
- `mem_op_i` in 4: operation code.
  - 0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW.
  - 9–15 are treated as NONE with bubble forced to 1.
- `store_data_i` in XLEN: rs2 value for stores.
- `rd_i` in 5: destination register index.
- `stall_i` in 1: global pipeline stall. Gates acceptance only.
- `stall_o` out 1: busy; holds the upstream stages.
- `dmem_req_o` out 1: memory request.
- `dmem_we_o` out 1: 1 = store.
- `dmem_addr_o` out XLEN: word address, with `[1:0]` forced to 0.
- `dmem_be_o` out 4: byte enables.
- `dmem_wdata_o` out XLEN: store data, lane-replicated.
- `dmem_gnt_i` in 1: request accepted.
- `dmem_rvalid_i` in 1: read data valid.
- `dmem_rdata_i` in XLEN: read data.
- `wb_data_o` out XLEN: writeback value.
- `wb_rd_o` out 5: writeback register index.
- `wb_bubble_o` out 1: 1 = no writeback this cycle.
- `misalign_o` out 1: one-cycle misaligned-access flag.

## Operation
- **FSM states:** IDLE, REQ, RESP. `stall_o = (state != IDLE)`, decoded from the state register only, with no combinational input-to-`stall_o` path.
- **Acceptance:** happens at a clock edge where state = IDLE and `stall_i` = 0. When `stall_i` = 1 in IDLE, all registers hold.
- **Non-memory ops** (NONE, or `alu_bubble_i` = 1):
  - `wb_data_o` <= `alu_result_i`, `wb_rd_o` <= `rd_i`, `wb_bubble_o` <= `alu_bubble_i` (forced to 1 for opcodes 9–15).
  - State stays IDLE.
- **Alignment check:** LH/LHU/SH require `addr[0]` = 0; LW/SW require `addr[1:0]` = 0. On a misaligned op:
  - no request is issued;
  - `misalign_o` = 1 for one cycle and `wb_bubble_o` = 1;
  - state stays IDLE.
- **Aligned memory ops:** latch the address, op, rd, `dmem_be_o` and `dmem_wdata_o`; set `wb_bubble_o` = 1 and go to REQ.
  - Byte enables: byte op → `4'b0001 << addr[1:0]`; half → `4'b0011 << addr[1:0]`; word → `4'b1111`.
  - Store data replication: SB → `{4{d[7:0]}}`; SH → `{2{d[15:0]}}`; SW → `d`.
- **REQ state:**
  - `dmem_req_o` = 1; address, `we`, `be` and `wdata` are held stable until `dmem_gnt_i`.
  - On gnt, a store goes to IDLE with `wb_bubble_o` = 1; a load goes to RESP.
- **RESP state:**
  - `dmem_req_o` = 0; wait for `dmem_rvalid_i`.
  - On rvalid, extract the lane selected by `addr[1:0]`. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Register `wb_data_o`, set `wb_rd_o` = latched rd and `wb_bubble_o` = 0, then go to IDLE.
- `rvalid` in REQ is ignored.
- `gnt` in RESP is ignored.
- `stall_i` is ignored in REQ/RESP.
- `misalign_o` is 0 in every cycle other than the misalign cycle.

## Timing
- **Reset values:**
  - state IDLE;
  - `stall_o`, `dmem_req_o`, `dmem_we_o`, `misalign_o` = 0;
  - `dmem_addr_o`, `dmem_wdata_o`, `wb_data_o` = 0; `dmem_be_o` = 0; `wb_rd_o` = 0;
  - `wb_bubble_o` = 1.
- Reset asserted mid-transaction abandons it: `dmem_req_o` drops asynchronously and any later gnt/rvalid is ignored.
- Non-memory op or misalign: 1-cycle latency from acceptance edge to output.
- **Load with gnt in the first REQ cycle and rvalid the next cycle:**
  - acceptance at edge E0;
  - `req` high during cycle E0–E1;
  - RESP during E1–E2;
  - wb valid after E2.
  - `stall_o` is high for exactly 2 cycles.
- Store with immediate gnt: `stall_o` is high for 1 cycle.
- Each wait cycle on gnt or rvalid extends `stall_o` by one cycle.
- Upstream must hold its outputs while `stall_o` is high. The next op is accepted on the edge where state is again IDLE.

## Test plan
- **ALU pass-through:** NONE, `alu_result_i` = 0x1234_5678, rd = 5, bubble 0, gnt/rvalid idle → next cycle `wb_data_o` = 0x1234_5678, `wb_rd_o` = 5, `wb_bubble_o` = 0, `stall_o` = 0, `dmem_req_o` = 0.
- **Signed byte load:** LB at addr 0x103, gnt immediate, rvalid next cycle with rdata 0x80AA_BBCC → `dmem_addr_o` = 0x100, `be` = 0b1000, `wb_data_o` = 0xFFFF_FF80, `stall_o` high 2 cycles.
- **Unsigned half load:** same flow with LHU at addr 0x2, rdata 0x9ABC_1234 → `wb_data_o` = 0x0000_9ABC, `be` = 0b1100.
- **Store with delayed grant:** SH at addr 0x6, data 0xDEAD_BEEF, gnt delayed 3 cycles → `req`/`addr` 0x4/`be` 0b1100/`wdata` 0xBEEF_BEEF held stable for 3 cycles, `stall_o` high 3 cycles, `wb_bubble_o` = 1 throughout.
- **Misaligned word access:** LW at addr 0x2 → `misalign_o` pulse of 1 cycle, no `dmem_req_o`, `wb_bubble_o` = 1, `stall_o` = 0. Repeat with SW at addr 0x5 → same response.
- **Reset and stall corners:**
  - assert `nreset_i` low while in RESP, then release → all outputs at reset values, state IDLE, and a late rvalid is ignored;
  - `stall_i` = 1 in IDLE with a pending LW → no request and outputs hold.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: passes ALU results through to writeback or runs one
// request/grant/response data-memory transaction at a time, stalling upstream meanwhile.
module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clock_i,
  input  logic            nreset_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            alu_bubble_i,
  input  logic [3:0]      mem_op_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [4:0]      rd_i,
  input  logic            stall_i,
  output logic            stall_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic [XLEN-1:0] wb_data_o,
  output logic [4:0]      wb_rd_o,
  output logic            wb_bubble_o,
  output logic            misalign_o
);

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LH   = 4'd2;
  localparam logic [3:0] OP_LW   = 4'd3;
  localparam logic [3:0] OP_LBU  = 4'd4;
  localparam logic [3:0] OP_LHU  = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_nextState;

  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_wbData;
  logic [3:0]      r_op;
  logic [3:0]      r_be;
  logic [4:0]      r_rd;
  logic [4:0]      r_wbRd;
  logic            r_we;
  logic            r_wbBubble;
  logic            r_misalign;

  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_lane;
  logic [XLEN-1:0] w_loadData;
  logic [3:0]      w_be;
  logic            w_opValid;
  logic            w_isByte;
  logic            w_isHalf;
  logic            w_isWord;
  logic            w_isStore;
  logic            w_isMem;
  logic            w_misaligned;

  // Opcodes 9-15 are not memory ops; bubbled instructions never touch memory.
  always_comb begin
    w_opValid    = (mem_op_i <= OP_SW);
    w_isByte     = (mem_op_i == OP_LB) || (mem_op_i == OP_LBU) || (mem_op_i == OP_SB);
    w_isHalf     = (mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH);
    w_isWord     = (mem_op_i == OP_LW) || (mem_op_i == OP_SW);
    w_isStore    = (mem_op_i == OP_SB) || (mem_op_i == OP_SH) || (mem_op_i == OP_SW);
    w_isMem      = w_opValid && (mem_op_i != OP_NONE) && !alu_bubble_i;
    w_misaligned = (w_isHalf && alu_result_i[0]) ||
                   (w_isWord && (alu_result_i[1:0] != 2'b00));
    w_be         = 4'b1111;
    w_wdata      = store_data_i;
    if (w_isByte) begin
      w_be    = 4'b0001 << alu_result_i[1:0];
      w_wdata = {4{store_data_i[7:0]}};
    end else if (w_isHalf) begin
      w_be    = 4'b0011 << alu_result_i[1:0];
      w_wdata = {2{store_data_i[15:0]}};
    end
  end

  always_comb begin
    w_lane     = dmem_rdata_i >> {r_addr[1:0], 3'b000};
    w_loadData = w_lane;
    case (r_op)
      OP_LB:   w_loadData = {{24{w_lane[7]}}, w_lane[7:0]};
      OP_LBU:  w_loadData = {24'd0, w_lane[7:0]};
      OP_LH:   w_loadData = {{16{w_lane[15]}}, w_lane[15:0]};
      OP_LHU:  w_loadData = {16'd0, w_lane[15:0]};
      default: w_loadData = w_lane;
    endcase
  end

  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (!stall_i && w_isMem && !w_misaligned) w_nextState = REQ;
      REQ:     if (dmem_gnt_i) w_nextState = r_we ? IDLE : RESP;
      RESP:    if (dmem_rvalid_i) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // misalign is a single-cycle pulse, so it clears on every edge it is not set.
  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wbData   <= '0;
      r_op       <= OP_NONE;
      r_be       <= 4'b0000;
      r_rd       <= 5'd0;
      r_wbRd     <= 5'd0;
      r_we       <= 1'b0;
      r_wbBubble <= 1'b1;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!stall_i) begin
            if (!w_isMem) begin
              r_wbData   <= alu_result_i;
              r_wbRd     <= rd_i;
              r_wbBubble <= alu_bubble_i || !w_opValid;
            end else if (w_misaligned) begin
              r_misalign <= 1'b1;
              r_wbBubble <= 1'b1;
            end else begin
              r_addr     <= alu_result_i;
              r_op       <= mem_op_i;
              r_rd       <= rd_i;
              r_be       <= w_be;
              r_wdata    <= w_wdata;
              r_we       <= w_isStore;
              r_wbBubble <= 1'b1;
            end
          end
        end
        RESP: begin
          if (dmem_rvalid_i) begin
            r_wbData   <= w_loadData;
            r_wbRd     <= r_rd;
            r_wbBubble <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall_o      = (r_state != IDLE);
  assign dmem_req_o   = (r_state == REQ);
  assign dmem_we_o    = r_we;
  assign dmem_addr_o  = {r_addr[XLEN-1:2], 2'b00};
  assign dmem_be_o    = r_be;
  assign dmem_wdata_o = r_wdata;
  assign wb_data_o    = r_wbData;
  assign wb_rd_o      = r_wbRd;
  assign wb_bubble_o  = r_wbBubble;
  assign misalign_o   = r_misalign;

endmodule
